// File: rtl/mult_bcd_seq.sv
// Sequential shift-add multiplier feeding a double-dabble BCD converter and
// registered seven-segment digit drivers, launched by a start/busy/done handshake.
module mult_bcd_seq #(
    parameter int WIDTH      = 4,
    parameter int NDIG       = 3,
    parameter int BLANK_LZ   = 0,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in1,
    input  logic [WIDTH-1:0]      in2,
    output logic                  busy,
    output logic                  done,
    output logic [2*WIDTH-1:0]    prod,
    output logic [4*NDIG-1:0]     bcd,
    output logic [7*NDIG-1:0]     dig,
    output logic [1:0]            state_dbg
);

    // Handshake: start is sampled only in IDLE; busy is high in MULT and BCD;
    // done is a single-cycle pulse in DONE, when prod/bcd/dig have just updated.

    localparam int PW = 2 * WIDTH;
    localparam int BW = 4 * NDIG;
    localparam int CW = $clog2(2 * WIDTH + 1);

    function automatic logic [127:0] pow10(input int n);
        logic [127:0] r;
        r = 128'd1;
        for (int i = 0; i < n; i++) r = r * 128'd10;
        return r;
    endfunction

    localparam logic [127:0] MAX_OP = (128'd1 << WIDTH) - 128'd1;
    localparam logic [127:0] MAX_SQ = MAX_OP * MAX_OP;
    localparam logic [6:0]   SEG_BLANK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    if (pow10(NDIG) <= MAX_SQ) begin : g_ndig_check
        $error("mult_bcd_seq: NDIG too small to hold the largest product");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_BCD  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_add;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     bin_r;
    logic [PW-1:0]     bin_sh;
    logic [BW-1:0]     bcd_r;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_sh;
    logic [7*NDIG-1:0] dig_nxt;
    logic              lead;
    logic [3:0]        cur_d;
    logic [6:0]        cur_s;
    logic              lint_unused;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_MULT;
            S_MULT: if (cnt == CW'(WIDTH - 1)) state_nxt = S_BCD;
            S_BCD:  if (cnt == CW'(2 * WIDTH)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state == S_MULT) || (state == S_BCD);
    assign done      = (state == S_DONE);
    assign state_dbg = state;

    assign acc_add = mplier[0] ? (acc + mcand) : acc;

    // Double-dabble step: correct digits >= 5, then shift {bcd, bin} left by one.
    always_comb begin
        bcd_adj = bcd_r;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_r[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
        end
    end

    assign bcd_sh      = {bcd_adj[BW-2:0], bin_r[PW-1]};
    assign bin_sh      = {bin_r[PW-2:0], 1'b0};
    assign lint_unused = bcd_adj[BW-1];

    // Segment patterns for the final BCD value, with optional leading-zero blanking.
    always_comb begin
        dig_nxt = '0;
        lead    = (BLANK_LZ != 0);
        cur_d   = '0;
        cur_s   = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            cur_d = bcd_sh[4*i +: 4];
            cur_s = seg_of(cur_d);
            if (lead && (cur_d == 4'd0) && (i != 0)) cur_s = 7'h00;
            if (cur_d != 4'd0) lead = 1'b0;
            dig_nxt[7*i +: 7] = (ACTIVE_LOW != 0) ? ~cur_s : cur_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            bin_r  <= '0;
            bcd_r  <= '0;
            prod   <= '0;
            bcd    <= '0;
            dig    <= {NDIG{SEG_BLANK}};
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mcand  <= PW'(in1);
                        mplier <= in2;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_MULT: begin
                    acc    <= acc_add;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= (cnt == CW'(WIDTH - 1)) ? '0 : cnt + 1'b1;
                end
                S_BCD: begin
                    // Count 0 loads the product; counts 1..2*WIDTH are dabble steps.
                    if (cnt == '0) begin
                        bin_r <= acc;
                        bcd_r <= '0;
                    end else begin
                        bin_r <= bin_sh;
                        bcd_r <= bcd_sh;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(2 * WIDTH)) begin
                        prod <= acc;
                        bcd  <= bcd_sh;
                        dig  <= dig_nxt;
                        cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
